// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: FSM state encoding,
// the NOP bubble word and the sequential PC increment.
package instruction_fetch_unit_pkg;

  localparam logic [0:0]  ST_RUN   = 1'b0;
  localparam logic [0:0]  ST_FAULT = 1'b1;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: bubble has priority over load, otherwise holds.
// A bubble is a NOP with zero PC+4 and the valid bit cleared.
module if_id_register
  import instruction_fetch_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q,    instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q,    valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (bubble_i) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = 32'd0;
      valid_d    = 1'b0;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, RUN/FAULT FSM and IF/ID register.
// Optional feature macro: FETCH_PERF_COUNTERS_EN adds saturating fetch/stall counters.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 512
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  output logic [31:0] IM_Address,
  input  logic [31:0] IM_Instruction,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Fetch_Fault
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] Perf_FetchCount,
  output logic [31:0] Perf_StallCount
`endif
);

  localparam logic [31:0] PC_RESET_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] IMEM_LIMIT       = 32'(IMEM_WORDS);

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] pc_plus4;
  logic        pc_out_of_range;
  logic        ifid_load;
  logic        ifid_bubble;

  assign pc_plus4        = pc_q + PC_INCR;
  assign pc_out_of_range = ({2'b00, pc_q[31:2]} >= IMEM_LIMIT);

  // Redirect wins over everything, including FAULT and Stall; the word fetched
  // on that edge is wrong-path, so IF/ID is squashed. Flush only ever adds a bubble.
  always_comb begin
    pc_d        = pc_q;
    state_d     = state_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (Redirect_Valid) begin
      pc_d        = {Redirect_Target[31:2], 2'b00};
      state_d     = ST_RUN;
      ifid_bubble = 1'b1;
    end else if (state_q == ST_FAULT) begin
      ifid_bubble = 1'b1;
    end else if (Stall) begin
      ifid_bubble = Flush;
    end else if (pc_out_of_range) begin
      // Range is checked on the advancing edge, so a bad redirect target faults one edge later.
      state_d     = ST_FAULT;
      ifid_bubble = 1'b1;
    end else begin
      pc_d        = pc_plus4;
      ifid_load   = 1'b1;
      ifid_bubble = Flush;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q    <= PC_RESET_ALIGNED;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign IM_Address  = pc_q;
  assign Fetch_Fault = (state_q == ST_FAULT);

  if_id_register u_if_id (
    .clk_i      (Clk),
    .rst_n_i    (Reset_n),
    .load_i     (ifid_load),
    .bubble_i   (ifid_bubble),
    .instr_i    (IM_Instruction),
    .pc_plus4_i (pc_plus4),
    .instr_o    (IFID_Instruction),
    .pc_plus4_o (IFID_PCPlus4),
    .valid_o    (IFID_Valid)
  );

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (ifid_load && !ifid_bubble && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Perf_FetchCount = fetch_cnt_q;
  assign Perf_StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; instruction memory returns mem[i] = i*4.
module tb_instruction_fetch_unit;

  logic        Clk;
  logic        Reset_n;
  logic        Stall;
  logic        Flush;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic [31:0] IM_Address;
  logic [31:0] IM_Instruction;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        Fetch_Fault;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] Perf_FetchCount;
  logic [31:0] Perf_StallCount;
  logic [31:0] stall_base;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (512)
  ) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .Stall            (Stall),
    .Flush            (Flush),
    .Redirect_Valid   (Redirect_Valid),
    .Redirect_Target  (Redirect_Target),
    .IM_Address       (IM_Address),
    .IM_Instruction   (IM_Instruction),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PCPlus4     (IFID_PCPlus4),
    .IFID_Valid       (IFID_Valid),
    .Fetch_Fault      (Fetch_Fault)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .Perf_FetchCount  (Perf_FetchCount),
    .Perf_StallCount  (Perf_StallCount)
`endif
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory model: word i holds i*4, i.e. the word equals its own byte address.
  assign IM_Instruction = {IM_Address[31:2], 2'b00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic stall, input logic flush, input logic rv, input logic [31:0] tgt);
    Stall           = stall;
    Flush           = flush;
    Redirect_Valid  = rv;
    Redirect_Target = tgt;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc4, input logic [31:0] ins,
                            input logic vld);
    check({tag, "_pc4"},   IFID_PCPlus4,        pc4);
    check({tag, "_instr"}, IFID_Instruction,    ins);
    check({tag, "_valid"}, {31'd0, IFID_Valid}, {31'd0, vld});
  endtask

  initial begin
    Reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    check("rst_pc", IM_Address, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst_fault", {31'd0, Fetch_Fault}, 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
    check("rst_fetchcnt", Perf_FetchCount, 32'h0);
    check("rst_stallcnt", Perf_StallCount, 32'h0);
`endif
    @(negedge Clk);
    Reset_n = 1'b1;

    // Free run: four edges from PC=0
    for (int i = 1; i <= 4; i++) begin
      step();
      check_ifid($sformatf("run%0d", i), 32'(i * 4), 32'((i - 1) * 4), 1'b1);
      check($sformatf("run%0d_pc", i), IM_Address, 32'(i * 4));
    end
`ifdef FETCH_PERF_COUNTERS_EN
    check("fetchcnt4", Perf_FetchCount, 32'd4);
    stall_base = Perf_StallCount;
`endif

    // Stall three edges at PC=0x10
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("stall%0d_pc", i), IM_Address, 32'h10);
      check_ifid($sformatf("stall%0d", i), 32'h10, 32'hC, 1'b1);
    end
`ifdef FETCH_PERF_COUNTERS_EN
    check("stallcnt3", Perf_StallCount, stall_base + 32'd3);
`endif

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_ifid("resume", 32'h14, 32'h10, 1'b1);
    check("resume_pc", IM_Address, 32'h14);

    // Redirect to misaligned 0x23 while stalled
    drive(1'b1, 1'b0, 1'b1, 32'h23);
    step();
    check("redir_pc", IM_Address, 32'h20);
    check_ifid("redir", 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_ifid("redir_next", 32'h24, 32'h20, 1'b1);

    // Flush + Stall at PC=0x8, then Flush alone, then normal
    drive(1'b0, 1'b0, 1'b1, 32'h8);
    step();
    check("to8_pc", IM_Address, 32'h8);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check("flstall_pc", IM_Address, 32'h8);
    check_ifid("flstall", 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    check("flush_pc", IM_Address, 32'hC);
    check_ifid("flush", 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_ifid("postflush", 32'h10, 32'hC, 1'b1);

    // Last valid word 0x7FC fetches normally, then 0x800 faults
    drive(1'b0, 1'b0, 1'b1, 32'h7FC);
    step();
    check("to7fc_fault", {31'd0, Fetch_Fault}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_ifid("last_word", 32'h800, 32'h7FC, 1'b1);
    check("last_word_fault", {31'd0, Fetch_Fault}, 32'h0);
    step();
    check("edge_fault", {31'd0, Fetch_Fault}, 32'h1);
    check("edge_fault_pc", IM_Address, 32'h800);
    check_ifid("edge_fault", 32'h0, 32'h0, 1'b0);

    // Leave FAULT via redirect to 0x40
    drive(1'b0, 1'b0, 1'b1, 32'h40);
    step();
    check("exit_fault", {31'd0, Fetch_Fault}, 32'h0);
    check("exit_pc", IM_Address, 32'h40);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_ifid("exit_next", 32'h44, 32'h40, 1'b1);

    // Redirect straight to 0x800: no fault on the redirect edge, fault one edge later
    drive(1'b0, 1'b0, 1'b1, 32'h800);
    step();
    check("r800_fault0", {31'd0, Fetch_Fault}, 32'h0);
    check_ifid("r800", 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("r800_fault1", {31'd0, Fetch_Fault}, 32'h1);
    check_ifid("r800_f", 32'h0, 32'h0, 1'b0);
    step();
    check("r800_hold_pc", IM_Address, 32'h800);
    check("r800_hold_fault", {31'd0, Fetch_Fault}, 32'h1);

    // Asynchronous reset mid-cycle in FAULT with a redirect pending
    drive(1'b1, 1'b0, 1'b1, 32'h100);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_fault", {31'd0, Fetch_Fault}, 32'h0);
    check("arst_pc", IM_Address, 32'h0);
    check_ifid("arst", 32'h0, 32'h0, 1'b0);
    step();
    check("arst_hold_pc", IM_Address, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step();
    check_ifid("post_rst", 32'h4, 32'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
